// File: rtl/vga_map_ctrl.sv
// ============================================================================
// Module  : vga_map_ctrl
// Brief   : CPU bus slave for a tile-map RAM with a row-collapse engine that
//           shifts rows 0..R-1 down by one and clears row 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_map_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        ctrl_iomem_ready,
  output logic [31:0] ctrl_iomem_rdata,
  output logic        map_wen,
  output logic [11:0] map_waddr,
  output logic [3:0]  map_wdata,
  output logic [11:0] map_raddr,
  input  logic [3:0]  map_rdata,
  output logic        busy,
  output logic        done
);

  localparam int               COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [11:0]      C_COLS     = 12'(COLS);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(COLS - 1);
  localparam logic [5:0]       C_ROWS     = 6'(ROWS);
  localparam logic [3:0]       C_REG_MAP  = 4'h2;
  localparam logic [3:0]       C_REG_CTL  = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_CLR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state, w_state_n;
  logic [4:0]       r_row,   w_row_n;
  logic [COL_W-1:0] r_col,   w_col_n;
  logic             r_err,   w_err_n;

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic             r_cpu_wen;
  logic [11:0]      r_cpu_waddr;
  logic [3:0]       r_cpu_wdata;

  logic       w_req, w_is_wr, w_is_rd, w_map_req, w_ctl;
  logic       w_accept, w_ctl_wr_idle, w_row_ok, w_start, w_bad, w_status;
  logic       w_busy;
  logic [4:0] w_req_row;

  assign w_busy    = (r_state != S_IDLE);
  assign w_req     = iomem_valid && !r_ready;
  assign w_is_wr   = iomem_wstrb[0];
  assign w_is_rd   = (iomem_wstrb == 4'b0000);
  assign w_map_req = w_req && (iomem_addr[23:20] == C_REG_MAP) && w_is_wr;
  assign w_ctl     = (iomem_addr[23:20] == C_REG_CTL);
  assign w_req_row = iomem_wdata[4:0];
  assign w_row_ok  = ({1'b0, w_req_row} < C_ROWS);

  // Map writes wait for the engine to return to IDLE; everything else is acked at once.
  assign w_accept      = w_req && !(w_map_req && w_busy);
  assign w_ctl_wr_idle = w_accept && w_ctl && w_is_wr && !w_busy;
  assign w_start       = w_ctl_wr_idle && w_row_ok;
  assign w_bad         = w_ctl_wr_idle && !w_row_ok;
  assign w_status      = w_accept && w_ctl && w_is_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_err_n   = r_err;

    if (w_status) w_err_n = 1'b0;
    if (w_bad)    w_err_n = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_col_n   = '0;
          w_row_n   = w_req_row;
          w_state_n = (w_req_row == 5'd0) ? S_CLR : S_RD;
        end
      end
      S_RD: w_state_n = S_WR;
      S_WR: begin
        if (r_col != C_COL_LAST) begin
          w_col_n   = r_col + 1'b1;
          w_state_n = S_RD;
        end else begin
          w_col_n   = '0;
          w_row_n   = r_row - 5'd1;
          w_state_n = (r_row == 5'd1) ? S_CLR : S_RD;
        end
      end
      S_CLR: begin
        if (r_col == C_COL_LAST) begin
          w_col_n   = '0;
          w_state_n = S_DONE;
        end else begin
          w_col_n = r_col + 1'b1;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Bus response and the CPU map-write strobe share the acceptance edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_cpu_wen   <= 1'b0;
      r_cpu_waddr <= '0;
      r_cpu_wdata <= '0;
    end else begin
      r_ready     <= w_accept;
      r_rdata     <= w_status ? {30'b0, r_err, w_busy} : 32'b0;
      r_cpu_wen   <= w_accept && w_map_req;
      r_cpu_waddr <= (w_accept && w_map_req) ? iomem_addr[13:2]  : 12'b0;
      r_cpu_wdata <= (w_accept && w_map_req) ? iomem_wdata[3:0] : 4'b0;
    end
  end

  logic [11:0] w_rd_addr, w_wr_addr;
  assign w_rd_addr = (12'(r_row) - 12'd1) * C_COLS + 12'(r_col);
  assign w_wr_addr = 12'(r_row) * C_COLS + 12'(r_col);

  always_comb begin
    map_wen   = r_cpu_wen;
    map_waddr = r_cpu_waddr;
    map_wdata = r_cpu_wdata;
    map_raddr = 12'b0;
    case (r_state)
      S_RD: map_raddr = w_rd_addr;
      S_WR: begin
        map_wen   = 1'b1;
        map_waddr = w_wr_addr;
        map_wdata = map_rdata;
      end
      S_CLR: begin
        map_wen   = 1'b1;
        map_waddr = 12'(r_col);
        map_wdata = 4'b0;
      end
      default: ;
    endcase
  end

  assign ctrl_iomem_ready = r_ready;
  assign ctrl_iomem_rdata = r_rdata;
  assign busy             = w_busy;
  assign done             = (r_state == S_DONE);

endmodule

`default_nettype wire
